// File: rtl/seg_serial_if.sv
// seg_serial_if: request/pattern inputs and serial chain outputs of the segment serialiser
interface seg_serial_if;
    logic        update;
    logic [63:0] SEG_TXT;
    logic        flash;
    logic        seg_clk;
    logic        seg_sout;
    logic        SEG_PEN;
    logic        seg_clrn;
    logic        busy;
    logic        frame_done;
    modport master (
        input  update, SEG_TXT,
        output flash, seg_clk, seg_sout, SEG_PEN, seg_clrn, busy, frame_done
    );
    modport slave (
        output update, SEG_TXT,
        input  flash, seg_clk, seg_sout, SEG_PEN, seg_clrn, busy, frame_done
    );
endinterface

// File: rtl/seg_serial_ctrl.sv
// seg_serial_ctrl: shifts a 64-bit segment pattern MSB first into an external chain,
// then latches it; frames come from update requests or a free-running refresh timer.
module seg_serial_ctrl #(
    parameter int DIV       = 2,
    parameter int REFRESH   = 1048576,
    parameter int FLASH_DIV = 25000000
) (
    input logic          clk,
    input logic          rst,
    seg_serial_if.master bus
);
    localparam int RW = $clog2(REFRESH + 1);
    localparam int FW = $clog2(FLASH_DIV + 1);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH - 1);
    localparam logic [FW-1:0] FL_MAX  = FW'(FLASH_DIV - 1);
    localparam logic [8:0]    P_HALF  = 9'(DIV - 1);
    localparam logic [8:0]    P_END   = 9'(2 * DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t        r_state, w_state_nxt;
    logic [63:0]   r_shreg, w_shreg_nxt;
    logic [5:0]    r_bit, w_bit_nxt;
    logic [8:0]    r_phase, w_phase_nxt;
    logic          r_seg_clk, w_seg_clk_nxt;
    logic          r_sout, w_sout_nxt;
    logic          r_pen, w_pen_nxt;
    logic          r_done, w_done_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_pending, w_pending_nxt;
    logic [RW-1:0] r_refresh;
    logic [FW-1:0] r_flash_cnt;
    logic          r_flash;
    logic          r_clrn;
    logic          w_tick;
    logic          w_fwrap;

    assign w_tick  = (r_refresh == REF_MAX);
    assign w_fwrap = (r_flash_cnt == FL_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_nxt     = r_bit;
        w_phase_nxt   = r_phase + 9'd1;
        w_seg_clk_nxt = r_seg_clk;
        w_sout_nxt    = r_sout;
        w_pen_nxt     = r_pen;
        w_done_nxt    = 1'b0;
        w_busy_nxt    = r_busy;
        // requests arriving mid-frame coalesce into a single follow-up frame
        w_pending_nxt = r_pending | bus.update | w_tick;
        case (r_state)
            IDLE: begin
                w_phase_nxt   = '0;
                w_pending_nxt = 1'b0;
                if (bus.update || r_pending || w_tick) begin
                    w_state_nxt   = SHIFT;
                    w_shreg_nxt   = bus.SEG_TXT;
                    w_bit_nxt     = '0;
                    w_seg_clk_nxt = 1'b0;
                    w_sout_nxt    = bus.SEG_TXT[63];
                    w_busy_nxt    = 1'b1;
                end
            end
            SHIFT: begin
                if (r_phase == P_HALF) w_seg_clk_nxt = 1'b1;
                if (r_phase == P_END) begin
                    w_phase_nxt   = '0;
                    w_seg_clk_nxt = 1'b0;
                    w_shreg_nxt   = {r_shreg[62:0], 1'b0};
                    w_bit_nxt     = r_bit + 6'd1;
                    if (r_bit == 6'd63) begin
                        w_state_nxt = LATCH;
                        w_pen_nxt   = 1'b1;
                    end else begin
                        w_sout_nxt = r_shreg[62];
                    end
                end
            end
            LATCH: begin
                if (r_phase == P_HALF) begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = '0;
                    w_pen_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit     <= '0;
            r_phase   <= '0;
            r_seg_clk <= 1'b0;
            r_sout    <= 1'b0;
            r_pen     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit     <= w_bit_nxt;
            r_phase   <= w_phase_nxt;
            r_seg_clk <= w_seg_clk_nxt;
            r_sout    <= w_sout_nxt;
            r_pen     <= w_pen_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh   <= '0;
            r_flash_cnt <= '0;
            r_flash     <= 1'b0;
            r_clrn      <= 1'b0;
        end else begin
            r_refresh   <= w_tick ? '0 : r_refresh + RW'(1);
            r_flash_cnt <= w_fwrap ? '0 : r_flash_cnt + FW'(1);
            r_flash     <= r_flash ^ w_fwrap;
            r_clrn      <= 1'b1;
        end
    end

    assign bus.flash      = r_flash;
    assign bus.seg_clk    = r_seg_clk;
    assign bus.seg_sout   = r_sout;
    assign bus.SEG_PEN    = r_pen;
    assign bus.seg_clrn   = r_clrn;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
endmodule

// File: tb/tb_seg_serial_ctrl.sv
// tb_seg_serial_ctrl: random traffic against a timing model on one instance,
// table vectors and corner sequences on a second instance with refresh out of reach.
module tb_seg_serial_ctrl;
    localparam int D  = 2;
    localparam int RA = 300;
    localparam int FA = 4;
    localparam int FL = 129 * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    seg_serial_if ia();
    seg_serial_if ib();

    seg_serial_ctrl #(.DIV(D), .REFRESH(RA), .FLASH_DIV(FA)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
    seg_serial_ctrl #(.DIV(D)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         e;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[13];

    int          a_n, a_s;
    bit          a_act, a_pend;
    logic        a_sout;
    logic [63:0] a_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected outputs come from elapsed cycles since the frame start edge
    task automatic a_cyc(input logic upd, input logic [63:0] txt, input logic r);
        int   e;
        logic eb, ec, ep, ed;
        bit   tick;
        ia.update  = upd;
        ia.SEG_TXT = txt;
        rst_a      = r;
        if (r) begin
            a_act = 0; a_pend = 0; a_n = 0; a_sout = 1'b0;
        end else begin
            tick = (a_n % RA) == RA - 1;
            if (!a_act) begin
                if (upd || a_pend || tick) begin
                    a_act = 1; a_s = a_n + 1; a_data = txt; a_pend = 0;
                end
            end else if (upd || tick) a_pend = 1;
            a_n++;
        end
        eb = 0; ec = 0; ep = 0; ed = 0;
        if (a_act) begin
            e = a_n - a_s;
            if (e < 128 * D) begin
                eb = 1; ec = (e % (2 * D)) >= D; a_sout = a_data[63 - e / (2 * D)];
            end else if (e < FL) begin
                eb = 1; ep = 1; a_sout = a_data[0];
            end else begin
                ed = 1; a_sout = a_data[0]; a_act = 0;
            end
        end
        @(posedge clk); #1;
        chk("A_outputs", {ia.busy, ia.seg_clk, ia.seg_sout, ia.SEG_PEN, ia.frame_done, ia.flash, ia.seg_clrn},
            {eb, ec, a_sout, ep, ed, r ? 1'b0 : 1'((a_n / FA) % 2), ~r});
    endtask

    task automatic b_cyc(input logic upd, input logic [63:0] txt, input logic r);
        ib.update  = upd;
        ib.SEG_TXT = txt;
        rst_b      = r;
        @(posedge clk); #1;
    endtask

    function automatic logic [6:0] b_outs();
        return {ib.busy, ib.seg_clk, ib.seg_sout, ib.SEG_PEN, ib.frame_done, ib.flash, ib.seg_clrn};
    endfunction

    task automatic a_proc();
        logic [7:0] fs;
        int dn;
        a_cyc(0, 0, 1);
        a_cyc(0, 0, 1);
        fs[0] = ia.flash;
        for (int k = 1; k < 8; k++) begin
            a_cyc(0, 0, 0);
            fs[k] = ia.flash;
        end
        chk("A_flash_seq", fs, 8'hF0);
        while (a_n != RA - 1) a_cyc(0, 0, 0);
        a_cyc(1, 64'hDEAD_BEEF_0123_4567, 0);
        dn = 0;
        for (int k = 0; k < RA - 1; k++) begin
            a_cyc(0, 0, 0);
            dn += int'(ia.frame_done);
            if (a_n == RA + FL + 1) chk("A_coincide_idle", ia.busy, 0);
        end
        chk("A_coincide_frames", dn, 1);
        for (int k = 0; k < 20000; k++)
            a_cyc($urandom_range(0, 199) == 0, {$urandom(), $urandom()}, $urandom_range(0, 2999) == 0);
    endtask

    task automatic b_proc();
        logic [63:0] txt, t1, stream;
        logic        prev;
        int j, rises, pens, done_at, dn, d2, b259, bsy;
        tbl[0]  = '{0,   5'b01010};
        tbl[1]  = '{1,   5'b01010};
        tbl[2]  = '{2,   5'b11010};
        tbl[3]  = '{3,   5'b11010};
        tbl[4]  = '{4,   5'b00010};
        tbl[5]  = '{6,   5'b10010};
        tbl[6]  = '{250, 5'b10010};
        tbl[7]  = '{252, 5'b01010};
        tbl[8]  = '{255, 5'b11010};
        tbl[9]  = '{256, 5'b01110};
        tbl[10] = '{257, 5'b01110};
        tbl[11] = '{258, 5'b01001};
        tbl[12] = '{259, 5'b01000};
        b_cyc(0, 0, 1);
        b_cyc(0, 0, 1);
        chk("B_reset_outs", b_outs(), 0);
        b_cyc(0, 0, 0);
        chk("B_clrn_release", {ib.seg_clrn, ib.busy}, 2'b10);

        txt = 64'h8000_0000_0000_0001;
        j = 0; rises = 0; pens = 0; done_at = -1; prev = 1'b0;
        for (int e = 0; e <= 259; e++) begin
            b_cyc(e == 0, txt, 0);
            rises += int'(!prev && ib.seg_clk);
            prev = ib.seg_clk;
            pens += int'(ib.SEG_PEN);
            if (ib.frame_done) done_at = e;
            if (j < 13 && tbl[j].e == e) begin
                chk($sformatf("B_vec_e%0d", e), {ib.seg_clk, ib.seg_sout, ib.SEG_PEN, ib.busy, ib.frame_done}, tbl[j].exp);
                j++;
            end
        end
        chk("B_clk_rises", rises, 64);
        chk("B_pen_cycles", pens, D);
        chk("B_done_cycle", done_at, FL);

        dn = 0; d2 = -1; b259 = 0; bsy = 0;
        for (int e = 0; e <= 900; e++) begin
            b_cyc(e == 0 || e == 10 || e == 50 || e == 100, 64'h1234, 0);
            if (ib.frame_done) begin
                dn++;
                if (e > FL) d2 = e;
            end
            if (e == FL + 1) b259 = int'(ib.busy);
            if (e >= 2 * FL + 2) bsy += int'(ib.busy);
        end
        chk("B_coalesce_frames", dn, 2);
        chk("B_second_done", d2, 2 * FL + 1);
        chk("B_no_gap", b259, 1);
        chk("B_no_third", bsy, 0);

        t1 = 64'hA5C3_0F1E_9B27_64D8;
        stream = '0; prev = 1'b0;
        for (int e = 0; e <= FL + 1; e++) begin
            b_cyc(e == 0, e < 40 ? t1 : ~t1, 0);
            if (!prev && ib.seg_clk) stream = {stream[62:0], ib.seg_sout};
            prev = ib.seg_clk;
        end
        chk("B_captured_stream", stream, t1);

        for (int e = 0; e <= 80; e++) b_cyc(e == 0 || e == 30, '1, 0);
        b_cyc(0, '1, 1);
        chk("B_abort_outs", b_outs(), 0);
        b_cyc(0, '1, 1);
        chk("B_abort_clrn_held", ib.seg_clrn, 0);
        b_cyc(0, '1, 0);
        chk("B_abort_release", {ib.seg_clrn, ib.busy}, 2'b10);
        pens = 0; bsy = 0;
        for (int k = 0; k < 100; k++) begin
            b_cyc(0, '1, 0);
            pens += int'(ib.SEG_PEN);
            bsy  += int'(ib.busy);
        end
        chk("B_abort_no_pen", pens, 0);
        chk("B_abort_stay_idle", bsy, 0);
    endtask

    initial begin
        fork
            a_proc();
            b_proc();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_serial_ctrl.md
SEG_SERIAL_CTRL -- requirements
Module: seg_serial_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 2, giving the half-period of seg_clk in clk cycles (legal range 1..255).
REQ-002 The block SHALL have parameter REFRESH, default 1048576, giving the auto-refresh frame period in clk cycles (legal range ≥ 2).
REQ-003 The block SHALL have parameter FLASH_DIV, default 25000000, giving the clk cycles per flash toggle (legal range ≥ 1).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have port update  in  1  request an immediate frame transfer.
REQ-006 The block SHALL have port SEG_TXT  in  64  segment pattern for 8 digits; digit 0 is in [7:0].
REQ-007 The block SHALL have port flash  out  1  blink enable for the digit encoders.
REQ-008 The block SHALL have port seg_clk  out  1  serial shift clock to the external shift-register chain.
REQ-009 The block SHALL have port seg_sout  out  1  serial data, MSB first.
REQ-010 The block SHALL have port SEG_PEN  out  1  latch pulse to the shift-register chain.
REQ-011 The block SHALL have port seg_clrn  out  1  active-low clear to the chain.
REQ-012 The block SHALL have port busy  out  1  high while a frame is in progress.
REQ-013 The block SHALL have port frame_done  out  1  single-cycle pulse at frame end.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and LATCH.
REQ-015 A frame SHALL start in IDLE when update=1, pending=1, or the refresh counter is at REFRESH-1.
- At that edge, SEG_TXT is captured into a 64-bit shift register, the bit count is set to 0, the phase count is set to 0, the state becomes SHIFT and busy becomes 1.
REQ-016 SEG_TXT SHALL be sampled only at frame start; changes during a frame SHALL NOT affect the frame.
REQ-017 In SHIFT, each bit SHALL last 2*DIV cycles:
- seg_clk=0 for the first DIV cycles, then seg_clk=1 for DIV cycles.
- seg_sout equals the shift register MSB for the whole bit period.
- The shift register shifts left by 1 after the bit period ends.
REQ-018 The first bit sent SHALL be SEG_TXT[63] and the last SHALL be SEG_TXT[0], for exactly 64 seg_clk rising edges per frame.
REQ-019 After bit 63 completes, the state SHALL become LATCH with seg_clk=0; SEG_PEN SHALL be 1 for exactly DIV cycles, then the state SHALL return to IDLE.
REQ-020 frame_done SHALL pulse for 1 cycle on the cycle the state returns to IDLE; busy SHALL be 0 from that same edge.
REQ-021 Total frame length SHALL be 128*DIV + DIV cycles (258 for DIV=2).
REQ-022 update asserted while busy=1 SHALL set pending; multiple requests SHALL coalesce into one.
- pending clears when the next frame starts.
- The next frame starts on the first IDLE cycle, so there are 0 idle cycles between frames.
REQ-023 The refresh counter SHALL count 0..REFRESH-1 and wrap, free-running and independent of busy.
- A refresh tick during busy SHALL set pending.
REQ-024 If update and a refresh tick coincide, exactly one frame SHALL start.
REQ-025 The flash counter SHALL count 0..FLASH_DIV-1; flash SHALL toggle at each wrap, giving a period of 2*FLASH_DIV cycles.
REQ-026 In IDLE, seg_clk, SEG_PEN and frame_done SHALL be 0, and seg_sout SHALL hold its last value.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 While rst=1 the block SHALL force:
- state=IDLE, busy=0, seg_clk=0, seg_sout=0, SEG_PEN=0, frame_done=0, flash=0, seg_clrn=0;
- pending=0, and refresh, flash, bit and phase counters all 0.
REQ-029 seg_clrn SHALL be 1 from the first clock edge with rst=0 onward.
REQ-030 rst asserted mid-frame SHALL abort the frame on that edge; no SEG_PEN pulse SHALL occur, and the pending request SHALL be discarded.

Verification
REQ-031 DIV=2, SEG_TXT=64'h8000_0000_0000_0001, one-cycle update -> sout=1 for bit 0, 0 for bits 1..62, 1 for bit 63; 64 seg_clk rises; SEG_PEN high 2 cycles; frame_done at cycle 258.
REQ-032 update pulsed 3 times during a frame -> exactly one extra frame follows with no IDLE gap; no third frame.
REQ-033 REFRESH=300, no update -> frames start at cycles 299, 599, ...; busy duty 258/300.
REQ-034 rst asserted at bit 20 -> same-edge outputs at reset values; no SEG_PEN pulse; seg_clrn=0 during rst; after release, idle until the next trigger.
REQ-035 SEG_TXT changed at bit 10 of a frame -> serial stream equals the value captured at frame start.
REQ-036 FLASH_DIV=4 -> flash reads 0,0,0,0,1,1,1,1,... after reset; update and a refresh tick on the same edge -> a single frame.
